// File: rtl/key_pkg.sv
// Shared types and constants for the Tetris button debouncer.
// Key indices name the bit positions of the key_* buses.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD_WAIT = 2'd1,
    HELD_RPT  = 2'd2
  } key_state_e;

  localparam int DEF_NUM_KEYS     = 5;
  localparam int DEF_STABLE_TICKS = 20;
  localparam int DEF_REPEAT_DELAY = 250;
  localparam int DEF_REPEAT_RATE  = 60;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_SOFT  = 3;
  localparam int KEY_HARD  = 4;

  // Bits needed to hold a counter that counts up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// One debounced key channel: input synchroniser, debounce and repeat
// counters, and the press/hold/repeat FSM. All updates gated by tick.
module key_fsm
  import key_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic srst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_strobe,
  output logic release_strobe,
  output logic repeat_strobe
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DEB_W   = cnt_width(STABLE_TICKS);
  localparam int RPT_W   = cnt_width(RPT_MAX);

  // Terminal values minus one: the increment that would reach the terminal
  // value fires the transition instead, so counters never hold it.
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(STABLE_TICKS - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic             sync_reg;
  logic             ks_reg;
  key_state_e       state_reg, state_next;
  logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             repeat_reg, repeat_next;
  logic [RPT_W-1:0] rpt_last;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg    <= 1'b0;
      ks_reg      <= 1'b0;
      state_reg   <= RELEASED;
      deb_cnt_reg <= '0;
      rpt_cnt_reg <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      sync_reg    <= raw;
      ks_reg      <= sync_reg;
      state_reg   <= state_next;
      deb_cnt_reg <= deb_cnt_next;
      rpt_cnt_reg <= rpt_cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      repeat_reg  <= repeat_next;
    end
  end

  assign rpt_last = (state_reg == HELD_WAIT) ? DELAY_LAST : RATE_LAST;

  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    rpt_cnt_next = rpt_cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;

    if (tick) begin
      case (state_reg)
        RELEASED: begin
          if (!ks_reg) begin
            deb_cnt_next = '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_next   = HELD_WAIT;
            deb_cnt_next = '0;
            rpt_cnt_next = '0;
            level_next   = 1'b1;
            press_next   = 1'b1;
          end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
          end
        end

        HELD_WAIT, HELD_RPT: begin
          if (!ks_reg) begin
            // Release candidate: repeat progress is frozen, not lost.
            if (deb_cnt_reg == DEB_LAST) begin
              state_next   = RELEASED;
              deb_cnt_next = '0;
              rpt_cnt_next = '0;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              deb_cnt_next = deb_cnt_reg + 1'b1;
            end
          end else begin
            deb_cnt_next = '0;
            if (rpt_cnt_reg == rpt_last) begin
              state_next   = HELD_RPT;
              rpt_cnt_next = '0;
              repeat_next  = 1'b1;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next   = RELEASED;
          deb_cnt_next = '0;
          rpt_cnt_next = '0;
          level_next   = 1'b0;
        end
      endcase
    end
  end

  assign level          = level_reg;
  assign press_strobe   = press_reg;
  assign release_strobe = release_reg;
  assign repeat_strobe  = repeat_reg;

endmodule

// File: rtl/key_debounce.sv
// Debounce and auto-repeat for the game buttons. The ms divider output is
// sampled as data to form a shared tick; every key gets its own channel.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS     = DEF_NUM_KEYS,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                origin_clk,
  input  logic                rst,
  input  logic                ms_clk_in,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  logic       ms_sync1_reg;
  logic       ms_sync2_reg;
  logic       ms_prev_reg;
  logic [1:0] fill_reg;
  logic       armed_reg;
  logic       tick_reg;

  // The synchroniser's reset zeros are not a real low level; arming waits
  // until genuine samples have filled it and shown ms_clk_in low, so a wave
  // that is high across reset release does not produce a tick.
  always_ff @(posedge origin_clk) begin
    if (rst) begin
      ms_sync1_reg <= 1'b0;
      ms_sync2_reg <= 1'b0;
      ms_prev_reg  <= 1'b0;
      fill_reg     <= 2'b00;
      armed_reg    <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      ms_sync1_reg <= ms_clk_in;
      ms_sync2_reg <= ms_sync1_reg;
      ms_prev_reg  <= ms_sync2_reg;
      fill_reg     <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && !ms_sync2_reg) begin
        armed_reg <= 1'b1;
      end
      tick_reg     <= armed_reg & ms_sync2_reg & ~ms_prev_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_fsm #(
        .STABLE_TICKS(STABLE_TICKS),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
      ) u_key_fsm (
        .clk           (origin_clk),
        .srst          (rst),
        .tick          (tick_reg),
        .raw           (key_raw[gi]),
        .level         (key_level[gi]),
        .press_strobe  (key_press[gi]),
        .release_strobe(key_release[gi]),
        .repeat_strobe (key_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: tick-level reference model of the key rules,
// expected outputs scheduled per cycle and compared on every falling edge.
module tb_key_debounce;
  import key_pkg::*;

  localparam int NK = 5;
  localparam int ST = 3;
  localparam int RD = 4;
  localparam int RR = 2;

  logic          origin_clk = 1'b0;
  logic          rst = 1'b1;
  logic          ms_clk_in = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  key_debounce #(
    .NUM_KEYS(NK), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .origin_clk (origin_clk),
    .rst        (rst),
    .ms_clk_in  (ms_clk_in),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 origin_clk = ~origin_clk;

  int cyc = 0;
  always @(posedge origin_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;
  bit check_en = 1'b0;

  // Reference model: per key, accepted level, run of disagreeing ticks,
  // and number of pressed ticks since the accepted press.
  bit m_level[NK];
  int m_run[NK];
  int m_held[NK];

  logic [NK-1:0] sch_press[int];
  logic [NK-1:0] sch_rel[int];
  logic [NK-1:0] sch_rpt[int];
  logic [NK-1:0] sch_lvl[int];
  logic [NK-1:0] exp_level = '0;
  logic [NK-1:0] exp_tmp;
  logic [NK-1:0] rv = '0;

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  always @(negedge origin_clk) begin
    if (check_en) begin
      if (sch_lvl.exists(cyc)) exp_level = sch_lvl[cyc];
      chk("level", key_level, exp_level);
      exp_tmp = sch_press.exists(cyc) ? sch_press[cyc] : '0;
      chk("press", key_press, exp_tmp);
      exp_tmp = sch_rel.exists(cyc) ? sch_rel[cyc] : '0;
      chk("release", key_release, exp_tmp);
      exp_tmp = sch_rpt.exists(cyc) ? sch_rpt[cyc] : '0;
      chk("repeat", key_repeat, exp_tmp);
    end
  end

  task automatic next_cyc();
    @(posedge origin_clk);
    #1;
  endtask

  // Apply the rules for one tick sampling v; the DUT shows the result four
  // edges after the edge at which ms_clk_in was driven high.
  task automatic model_tick(input logic [NK-1:0] v, input int p);
    logic [NK-1:0] pr, rl, rp, lv;
    pr = '0; rl = '0; rp = '0; lv = '0;
    for (int k = 0; k < NK; k++) begin
      if (!m_level[k]) begin
        if (v[k]) begin
          m_run[k]++;
          if (m_run[k] == ST) begin
            m_level[k] = 1'b1; pr[k] = 1'b1; m_run[k] = 0; m_held[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end else if (!v[k]) begin
        m_run[k]++;
        if (m_run[k] == ST) begin
          m_level[k] = 1'b0; rl[k] = 1'b1; m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
        m_held[k]++;
        if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RR == 0)) rp[k] = 1'b1;
      end
      lv[k] = m_level[k];
    end
    sch_press[p+4] = pr;
    sch_rel[p+4]   = rl;
    sch_rpt[p+4]   = rp;
    sch_lvl[p+4]   = lv;
    n_ticks++;
    $display("tick %0d cyc=%0d raw=%b exp level=%b press=%b rel=%b rpt=%b",
             n_ticks, p, v, lv, pr, rl, rp);
  endtask

  task automatic do_tick(input logic [NK-1:0] keys);
    key_raw = keys;
    repeat (4) next_cyc();
    ms_clk_in = 1'b1;
    model_tick(keys, cyc);
    repeat (4) next_cyc();
    ms_clk_in = 1'b0;
  endtask

  task automatic do_reset();
    int c;
    c = cyc;
    rst = 1'b1;
    sch_lvl[c+1] = '0;
    for (int k = 0; k < NK; k++) begin
      m_level[k] = 1'b0; m_run[k] = 0; m_held[k] = 0;
    end
    $display("reset at cyc=%0d ms_clk_in=%b", c, ms_clk_in);
    next_cyc();
    rst = 1'b0;
  endtask

  // One tick whose ms_clk_in high phase spans a one-cycle reset pulse.
  task automatic tick_with_reset_high(input logic [NK-1:0] keys);
    key_raw = keys;
    repeat (4) next_cyc();
    ms_clk_in = 1'b1;
    model_tick(keys, cyc);
    repeat (6) next_cyc();
    do_reset();
    next_cyc();
    ms_clk_in = 1'b0;
  endtask

  initial begin
    logic [NK-1:0] k0, k1, k2, k3, k4;
    k0 = NK'(1) << KEY_LEFT;
    k1 = NK'(1) << KEY_RIGHT;
    k2 = NK'(1) << KEY_ROT;
    k3 = NK'(1) << KEY_SOFT;
    k4 = NK'(1) << KEY_HARD;
    for (int k = 0; k < NK; k++) begin
      m_level[k] = 1'b0; m_run[k] = 0; m_held[k] = 0;
    end

    next_cyc();
    next_cyc();
    check_en = 1'b1;
    next_cyc();
    rst = 1'b0;
    repeat (3) next_cyc();

    // Clean press then release on the left key.
    repeat (4) do_tick(k0);
    repeat (3) do_tick('0);

    // Bounce on the right key, then a steady press.
    do_tick(k1); do_tick('0); do_tick(k1); do_tick('0);
    repeat (3) do_tick(k1);
    repeat (3) do_tick('0);

    // Auto-repeat on rotate.
    repeat (15) do_tick(k2);
    repeat (3) do_tick('0);

    // Release with a glitch on soft-drop.
    repeat (3) do_tick(k3);
    do_tick('0); do_tick('0); do_tick(k3);
    do_tick('0); do_tick('0); do_tick('0);

    // Reset while hard-drop is repeating; it must re-qualify.
    repeat (9) do_tick(k4);
    do_reset();
    repeat (4) do_tick(k4);
    repeat (3) do_tick('0);

    // Simultaneous keys, then reset while ms_clk_in is high.
    repeat (3) do_tick(k0 | k1);
    tick_with_reset_high(k0 | k1);
    repeat (4) do_tick(k0 | k1);
    repeat (3) do_tick('0);

    // Random key activity with a reset partway through.
    for (int t = 0; t < 80; t++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 5) == 0) rv[k] = ~rv[k];
      end
      do_tick(rv);
      if (t == 40) do_reset();
    end
    repeat (3) do_tick('0);
    repeat (8) next_cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
